// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-granular round-robin arbiter in front of the 1G MAC TX AXI-stream
// byte interface. A grant is held until tlast is accepted so frames never
// interleave. A length watchdog truncates runaway frames: the beat that
// reaches MAX_FRAME_LEN goes out with tlast=1/tuser=1, and the rest of that
// frame is swallowed in DRAIN.
//
// Build option: define ETH_TX_ARB_STATS_EN to add per-port frame and
// truncation counters (frame_count, trunc_count) with a stats_clear input.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick next requester round-robin (1-cycle bubble)
// XFER  | forwarding granted port's beats through the output register
// DRAIN | frame was truncated; consume and discard beats until tlast

module eth_tx_frame_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int CNT_WIDTH     = 16,
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BW = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic                   logic_clk,
    input  logic                   logic_rst_n,
    input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    input  logic [NUM_PORTS-1:0]   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic [NUM_PORTS-1:0]   port_enable,
    output logic [GW-1:0]          grant_id,
`ifdef ETH_TX_ARB_STATS_EN
    input  logic                           stats_clear,
    output logic [CNT_WIDTH*NUM_PORTS-1:0] frame_count,
    output logic [CNT_WIDTH*NUM_PORTS-1:0] trunc_count,
`endif
    output logic                   busy,
    output logic                   trunc_pulse
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]      tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            tuser_q, tuser_d;
    logic            trunc_q, trunc_d;

    logic [NUM_PORTS-1:0] cand;
    logic                 found;
    logic [GW-1:0]        pick;
    logic [GW-1:0]        idx;

    logic [7:0] sel_data;
    logic       sel_valid, sel_last, sel_user;
    logic       out_free;
    logic       sel_ready;
    logic       at_max;
    logic       trunc_now;
    logic       frame_end;
    logic       trunc_ev;

    // Round-robin search starting one past the last port that finished a frame
    always_comb begin
        cand  = s_axis_tvalid & port_enable;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = GW'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Mux the granted port's input beat
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == GW'(p)) begin
                sel_data  = s_axis_tdata[8*p +: 8];
                sel_valid = s_axis_tvalid[p];
                sel_last  = s_axis_tlast[p];
                sel_user  = s_axis_tuser[p];
            end
        end
    end

    // Next-state, output register load and per-port ready
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q & ~m_axis_tready;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        trunc_d      = 1'b0;
        sel_ready    = 1'b0;
        frame_end    = 1'b0;
        trunc_ev     = 1'b0;
        out_free     = ~tvalid_q | m_axis_tready;
        at_max       = (byte_cnt_q == BW'(MAX_FRAME_LEN - 1));
        trunc_now    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    byte_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                sel_ready = out_free;
                if (sel_valid && out_free) begin
                    trunc_now  = at_max & ~sel_last;
                    byte_cnt_d = (byte_cnt_q == BW'(MAX_FRAME_LEN)) ?
                                 byte_cnt_q : byte_cnt_q + BW'(1);
                    tdata_d    = sel_data;
                    tvalid_d   = 1'b1;
                    tlast_d    = sel_last | trunc_now;
                    tuser_d    = sel_user | trunc_now;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        frame_end    = 1'b1;
                        state_d      = IDLE;
                    end else if (trunc_now) begin
                        trunc_d  = 1'b1;
                        trunc_ev = 1'b1;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                sel_ready = 1'b1;
                if (sel_valid && sel_last) begin
                    last_grant_d = grant_q;
                    frame_end    = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready goes only to the granted port
    always_comb begin
        s_axis_tready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == GW'(p)) s_axis_tready[p] = sel_ready;
        end
    end

    // State and output register
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            byte_cnt_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            trunc_q      <= trunc_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign trunc_pulse   = trunc_q;

`ifdef ETH_TX_ARB_STATS_EN
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    // Saturating per-port counters; clear wins over a same-cycle increment
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (stats_clear) begin
            frame_cnt_d = '0;
            trunc_cnt_d = '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant_q == GW'(p)) begin
                    if (frame_end && (frame_cnt_q[p] != '1))
                        frame_cnt_d[p] = frame_cnt_q[p] + CNT_WIDTH'(1);
                    if (trunc_ev && (trunc_cnt_q[p] != '1))
                        trunc_cnt_d[p] = trunc_cnt_q[p] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign trunc_count = trunc_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter (NUM_PORTS=4, MAX_FRAME_LEN=8).
// Sources are per-port beat queues; expected output beats go to a
// scoreboard queue and are checked as the DUT emits them.

module tb_eth_tx_frame_arbiter;
    localparam int NP  = 4;
    localparam int MFL = 8;
    localparam int CW  = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int         lg;
        logic [3:0] en;
        logic [3:0] pend;
        int         exp_port;
    } arb_vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [8*NP-1:0] s_tdata;
    logic [NP-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]      m_tdata;
    logic            m_tvalid, m_tready, m_tlast, m_tuser;
    logic [NP-1:0]   port_enable;
    logic [1:0]      grant_id;
    logic            busy, trunc_pulse;
`ifdef ETH_TX_ARB_STATS_EN
    logic               stats_clear;
    logic [CW*NP-1:0]   frame_count, trunc_count;
`endif

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(MFL), .CNT_WIDTH(CW)) dut (
        .logic_clk    (clk),
        .logic_rst_n  (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .port_enable  (port_enable),
        .grant_id     (grant_id),
`ifdef ETH_TX_ARB_STATS_EN
        .stats_clear  (stats_clear),
        .frame_count  (frame_count),
        .trunc_count  (trunc_count),
`endif
        .busy         (busy),
        .trunc_pulse  (trunc_pulse)
    );

    beat_t      src_q [NP][$];
    beat_t      exp_q [$];
    logic [7:0] obs_q [$];
    int         errors = 0;
    int         checks = 0;
    logic       mtr_pat [4];
    int         trunc_seen = 0;
    int         stalls_seen = 0;
    logic       gap_chk = 1'b0;
    logic       have_prev = 1'b0;
    logic       prev_last = 1'b0;
    int         idle_run = 0;

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    function automatic bit src_empty();
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Source driver + output monitor; samples 1 time unit after the falling edge
    initial begin
        logic [NP-1:0] hs;
        logic          hold_v;
        beat_t         hold_b;
        beat_t         e;
        int            pat_idx;
        hs = '0;
        hold_v = 1'b0;
        hold_b = '0;
        pat_idx = 0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() > 0) begin
                    s_tvalid[p]       = 1'b1;
                    s_tdata[8*p +: 8] = src_q[p][0].data;
                    s_tlast[p]        = src_q[p][0].last;
                    s_tuser[p]        = src_q[p][0].user;
                end else begin
                    s_tvalid[p]       = 1'b0;
                    s_tdata[8*p +: 8] = 8'h00;
                    s_tlast[p]        = 1'b0;
                    s_tuser[p]        = 1'b0;
                end
            end
            m_tready = mtr_pat[pat_idx];
            pat_idx  = (pat_idx + 1) % 4;
            #1;
            hs = s_tvalid & s_tready;
            if (hold_v) begin
                check("stall_valid", int'(m_tvalid), 1);
                check("stall_hold", int'({m_tdata, m_tlast, m_tuser}), int'(hold_b));
            end
            hold_v = m_tvalid & ~m_tready;
            hold_b = mk(m_tdata, m_tlast, m_tuser);
            if (hold_v) stalls_seen++;
            if (m_tvalid && m_tready) begin
                if (gap_chk && have_prev) check("idle_gap", idle_run, prev_last ? 1 : 0);
                have_prev = 1'b1;
                prev_last = m_tlast;
                idle_run  = 0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", int'(m_tdata), int'(e.data));
                    check("out_last", int'(m_tlast), int'(e.last));
                    check("out_user", int'(m_tuser), int'(e.user));
                end else begin
                    obs_q.push_back(m_tdata);
                end
            end else if (!m_tvalid) begin
                idle_run++;
            end
            if (trunc_pulse) trunc_seen++;
        end
    end

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(posedge clk); #2;
            if (src_empty() && exp_q.size() == 0 && !m_tvalid && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: timeout, exp_q=%0d left, busy=%0b", name, exp_q.size(), busy);
        end
    endtask

    // Finish one frame on port lg so it becomes last_grant
    task automatic set_last_grant(input int lg);
        port_enable = NP'(1 << lg);
        src_q[lg].push_back(mk(8'hE0 | 8'(lg), 1'b1, 1'b0));
        wait_idle("setup_lg");
        obs_q.delete();
    endtask

    arb_vec_t vecs [6];

    initial begin
        int ts0;
        bit got;
        vecs[0] = '{lg: 1, en: 4'b1011, pend: 4'b1100, exp_port: 3};
        vecs[1] = '{lg: 0, en: 4'b1111, pend: 4'b1111, exp_port: 1};
        vecs[2] = '{lg: 3, en: 4'b1111, pend: 4'b1010, exp_port: 1};
        vecs[3] = '{lg: 2, en: 4'b0111, pend: 4'b1001, exp_port: 0};
        vecs[4] = '{lg: 1, en: 4'b1111, pend: 4'b0010, exp_port: 1};
        vecs[5] = '{lg: 3, en: 4'b1110, pend: 4'b0011, exp_port: 1};

        for (int i = 0; i < 4; i++) mtr_pat[i] = 1'b1;
        port_enable = '1;
`ifdef ETH_TX_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        rst_n = 1'b0;

        // Reset with every port requesting, then round-robin 0,1,2,3,0
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 3; b++)
                src_q[p].push_back(mk(8'(16*p + b), b == 2, 1'b0));
        for (int b = 0; b < 3; b++) src_q[0].push_back(mk(8'(8 + b), b == 2, 1'b0));
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 3; b++) exp_q.push_back(mk(8'(16*p + b), b == 2, 1'b0));
        for (int b = 0; b < 3; b++) exp_q.push_back(mk(8'(8 + b), b == 2, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", int'(m_tvalid), 0);
        check("rst_s_tready", int'(s_tready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_s_tvalid_driven", int'(s_tvalid), 4'hF);
        gap_chk = 1'b1;
        have_prev = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("first_grant", int'(grant_id), 0);
        check("first_busy", int'(busy), 1);
        wait_idle("round_robin");
        gap_chk = 1'b0;
        check("rr_no_extra", obs_q.size(), 0);

        // Arbitration table: first port served for a given history and mask
        foreach (vecs[i]) begin
            set_last_grant(vecs[i].lg);
            port_enable = vecs[i].en;
            for (int p = 0; p < NP; p++)
                if (vecs[i].pend[p]) src_q[p].push_back(mk(8'hC0 | 8'(p), 1'b1, 1'b0));
            got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(posedge clk); #2;
                got = (obs_q.size() > 0);
            end
            check($sformatf("arb_first_v%0d", i), got ? int'(obs_q[0]) : -1,
                  8'hC0 | vecs[i].exp_port);
            port_enable = '1;
            wait_idle("arb_drain");
            check($sformatf("arb_count_v%0d", i), obs_q.size(), $countones(vecs[i].pend));
            obs_q.delete();
        end

        // Masking: port 3 wins over disabled port 2; dropping its enable mid-frame is ignored
        set_last_grant(1);
        port_enable = 4'b1011;
        for (int b = 0; b < 4; b++) begin
            src_q[3].push_back(mk(8'hD0 + 8'(b), b == 3, 1'b0));
            exp_q.push_back(mk(8'hD0 + 8'(b), b == 3, 1'b0));
        end
        src_q[2].push_back(mk(8'hD8, 1'b1, 1'b0));
        exp_q.push_back(mk(8'hD8, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        port_enable = 4'b0011;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk); #2;
            got = (exp_q.size() <= 1) && !m_tvalid;
        end
        check("mask_frame_done", exp_q.size(), 1);
        check("mask_grant", int'(grant_id), 3);
        repeat (3) @(posedge clk);
        #2;
        check("mask_port2_held", int'(busy), 0);
        port_enable = '1;
        wait_idle("mask_drain");

        // Backpressure on port 2 with ready pattern 1,0,0,1
        mtr_pat[0] = 1'b1; mtr_pat[1] = 1'b0; mtr_pat[2] = 1'b0; mtr_pat[3] = 1'b1;
        ts0 = stalls_seen;
        for (int b = 0; b < 5; b++) begin
            src_q[2].push_back(mk(8'hA0 + 8'(b), b == 4, 1'b0));
            exp_q.push_back(mk(8'hA0 + 8'(b), b == 4, 1'b0));
        end
        wait_idle("backpressure");
        for (int i = 0; i < 4; i++) mtr_pat[i] = 1'b1;
        check("bp_stalls_seen", int'(stalls_seen > ts0), 1);

        // Truncation: 12-byte frame on port 1 cut at 8 bytes, port 2 next
`ifdef ETH_TX_ARB_STATS_EN
        @(posedge clk); #2;
        stats_clear = 1'b1;
        @(posedge clk); #2;
        stats_clear = 1'b0;
`endif
        set_last_grant(0);
        port_enable = '1;
        ts0 = trunc_seen;
        for (int b = 0; b < 12; b++) src_q[1].push_back(mk(8'h30 + 8'(b), b == 11, 1'b0));
        src_q[2].push_back(mk(8'h50, 1'b0, 1'b0));
        src_q[2].push_back(mk(8'h51, 1'b1, 1'b0));
        for (int b = 0; b < MFL; b++)
            exp_q.push_back(mk(8'h30 + 8'(b), b == MFL - 1, b == MFL - 1));
        exp_q.push_back(mk(8'h50, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h51, 1'b1, 1'b0));
        wait_idle("truncation");
        check("trunc_pulses", trunc_seen - ts0, 1);
        check("trunc_consumed", src_q[1].size(), 0);
        check("trunc_no_extra", obs_q.size(), 0);

`ifdef ETH_TX_ARB_STATS_EN
        check("stat_frame_p1", int'(frame_count[CW*1 +: CW]), 1);
        check("stat_trunc_p1", int'(trunc_count[CW*1 +: CW]), 1);
        check("stat_frame_p2", int'(frame_count[CW*2 +: CW]), 1);
        @(posedge clk); #2;
        stats_clear = 1'b1;
        @(posedge clk); #2;
        stats_clear = 1'b0;
        check("stat_clr_frame", int'(frame_count != '0), 0);
        check("stat_clr_trunc", int'(trunc_count != '0), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
